stw_sweep_controller: RTL and testbench



---
 rtl/stw_sweep_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_stw_sweep_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stw_sweep_controller.sv
// STW sweep controller: runs self-test words through every PE
// of the systolic array and records per-PE pass/fail.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   sweep_start       sweep request (sampled in IDLE)
//   array_idle        array is between tiles; gates sweep start
//   sweep_abort       abandon sweep, return to IDLE, no done
//   sweep_busy        high whenever not IDLE
//   sweep_done        one-cycle pulse on normal completion
//   fault_map         sticky per-PE fault bits
//   stw_mult_op1/op2  broadcast multiplier operands
//   stw_add_op        broadcast addend
//   stw_expected      broadcast expected result
//   stw_load_en       one-hot per-PE load strobe
//   stw_start         one-hot per-PE start strobe
//   stw_complete      per-PE complete (1 when idle)
//   stw_result        per-PE pass flag
//   timeout_map       per-PE watchdog hits (STW_TIMEOUT_EN only)
//
// Optional: define STW_TIMEOUT_EN to add the wait watchdog.
module stw_sweep_controller #(
  parameter int          WORD_SIZE      = 16,
  parameter int          NUM_PE         = 16,
  parameter int          NUM_VECTORS    = 4,
  parameter logic [15:0] SEED           = 16'hACE1,
  parameter int          TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sweep_start,
  input  logic                 array_idle,
  input  logic                 sweep_abort,
  output logic                 sweep_busy,
  output logic                 sweep_done,
  output logic [NUM_PE-1:0]    fault_map,
  output logic [WORD_SIZE-1:0] stw_mult_op1,
  output logic [WORD_SIZE-1:0] stw_mult_op2,
  output logic [WORD_SIZE-1:0] stw_add_op,
  output logic [WORD_SIZE-1:0] stw_expected,
  output logic [NUM_PE-1:0]    stw_load_en,
  output logic [NUM_PE-1:0]    stw_start,
  input  logic [NUM_PE-1:0]    stw_complete,
  input  logic [NUM_PE-1:0]    stw_result
`ifdef STW_TIMEOUT_EN
  ,
  output logic [NUM_PE-1:0]    timeout_map
`endif
);

  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int VW = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, CHECK, DONE
  } state_t;

  state_t          state;
  logic [PW-1:0]   pe_idx;
  logic [VW-1:0]   vec_idx;
  logic [15:0]     lfsr;
  logic [15:0]     lfsr_nxt;
  logic            pe_last;
  logic            vec_last;
  logic [PW-1:0]   pe_inc;

  // x^16+x^14+x^13+x^11+1, Fibonacci form, shifting left
  assign lfsr_nxt = {lfsr[14:0],
                     lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign pe_last  = (pe_idx == PW'(NUM_PE - 1));
  assign vec_last = (vec_idx == VW'(NUM_VECTORS - 1));
  assign pe_inc   = pe_idx + PW'(1);

  // 16-bit LFSR value truncated or zero-extended to the datapath
  function automatic logic [WORD_SIZE-1:0] fit(input logic [15:0] v);
    logic [WORD_SIZE+15:0] t;
    t = {{WORD_SIZE{1'b0}}, v};
    return t[WORD_SIZE-1:0];
  endfunction

  function automatic logic [15:0] rotl5(input logic [15:0] v);
    return {v[10:0], v[15:11]};
  endfunction

  function automatic logic [WORD_SIZE-1:0] calc(
    input logic [WORD_SIZE-1:0] a,
    input logic [WORD_SIZE-1:0] b,
    input logic [WORD_SIZE-1:0] c
  );
    logic [WORD_SIZE-1:0] r;
    r = a * b + c;
    return r;
  endfunction

  function automatic logic [NUM_PE-1:0] onehot(input logic [PW-1:0] i);
    logic [NUM_PE-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

`ifdef STW_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          t_hit;
  assign t_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pe_idx       <= '0;
      vec_idx      <= '0;
      lfsr         <= SEED;
      sweep_busy   <= 1'b0;
      sweep_done   <= 1'b0;
      fault_map    <= '0;
      stw_mult_op1 <= '0;
      stw_mult_op2 <= '0;
      stw_add_op   <= '0;
      stw_expected <= '0;
      stw_load_en  <= '0;
      stw_start    <= '0;
`ifdef STW_TIMEOUT_EN
      timeout_map  <= '0;
      tcnt         <= '0;
`endif
    end else begin
      sweep_done  <= 1'b0;
      stw_load_en <= '0;
      stw_start   <= '0;
      if (sweep_abort) begin
        state      <= IDLE;
        sweep_busy <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (sweep_start && array_idle) begin
              state        <= LOAD;
              sweep_busy   <= 1'b1;
              fault_map    <= '0;
              pe_idx       <= '0;
              vec_idx      <= '0;
              lfsr         <= SEED;
              stw_mult_op1 <= fit(SEED);
              stw_mult_op2 <= fit(rotl5(SEED));
              stw_add_op   <= fit(~SEED);
              stw_expected <= calc(fit(SEED), fit(rotl5(SEED)),
                                   fit(~SEED));
              stw_load_en  <= onehot('0);
`ifdef STW_TIMEOUT_EN
              timeout_map  <= '0;
`endif
            end
          end
          LOAD: begin
            state     <= START;
            stw_start <= onehot(pe_idx);
          end
          START: begin
            state <= WAIT_ACK;
`ifdef STW_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
          WAIT_ACK, WAIT_DONE: begin
`ifdef STW_TIMEOUT_EN
            tcnt <= tcnt + TW'(1);
            if (t_hit) begin
              fault_map[pe_idx]   <= 1'b1;
              timeout_map[pe_idx] <= 1'b1;
              vec_idx             <= '0;
              if (pe_last) begin
                state      <= DONE;
                sweep_done <= 1'b1;
              end else begin
                pe_idx      <= pe_inc;
                state       <= LOAD;
                stw_load_en <= onehot(pe_inc);
              end
            end else
`endif
            if (state == WAIT_ACK && !stw_complete[pe_idx])
              state <= WAIT_DONE;
            else if (state == WAIT_DONE && stw_complete[pe_idx])
              state <= CHECK;
          end
          CHECK: begin
            lfsr         <= lfsr_nxt;
            stw_mult_op1 <= fit(lfsr_nxt);
            stw_mult_op2 <= fit(rotl5(lfsr_nxt));
            stw_add_op   <= fit(~lfsr_nxt);
            stw_expected <= calc(fit(lfsr_nxt),
                                 fit(rotl5(lfsr_nxt)),
                                 fit(~lfsr_nxt));
            if (!stw_result[pe_idx] || vec_last) begin
              // a failing PE skips its remaining vectors
              if (!stw_result[pe_idx])
                fault_map[pe_idx] <= 1'b1;
              vec_idx <= '0;
              if (pe_last) begin
                state      <= DONE;
                sweep_done <= 1'b1;
              end else begin
                pe_idx      <= pe_inc;
                state       <= LOAD;
                stw_load_en <= onehot(pe_inc);
              end
            end else begin
              vec_idx     <= vec_idx + VW'(1);
              state       <= LOAD;
              stw_load_en <= onehot(pe_idx);
            end
          end
          DONE: begin
            state      <= IDLE;
            sweep_busy <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            sweep_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stw_sweep_controller.sv
// Directed bench for stw_sweep_controller with 4 behavioural
// STW PEs (fault, hang and no-ack injection per PE).
module tb_stw_sweep_controller;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sweep_start = 1'b0;
  logic          array_idle = 1'b1;
  logic          sweep_abort = 1'b0;
  logic          sweep_busy;
  logic          sweep_done;
  logic [NP-1:0] fault_map;
  logic [15:0]   op1, op2, addo, expv;
  logic [NP-1:0] load_en, start;
  logic [NP-1:0] comp, res;
`ifdef STW_TIMEOUT_EN
  logic [NP-1:0] timeout_map;
`endif

  logic [NP-1:0] mul_stuck = '0;
  logic [NP-1:0] hang = '0;
  logic [NP-1:0] noack = '0;
  logic [1:0]    cnt [NP];
  int            start_log[$];
  int            checks = 0;
  int            errors = 0;
  int            n;
  int            k;

  stw_sweep_controller #(
    .WORD_SIZE(16), .NUM_PE(NP), .NUM_VECTORS(2),
    .SEED(16'hACE1), .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk), .rst(rst),
    .sweep_start(sweep_start), .array_idle(array_idle),
    .sweep_abort(sweep_abort),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .fault_map(fault_map),
    .stw_mult_op1(op1), .stw_mult_op2(op2),
    .stw_add_op(addo), .stw_expected(expv),
    .stw_load_en(load_en), .stw_start(start),
    .stw_complete(comp), .stw_result(res)
`ifdef STW_TIMEOUT_EN
    , .timeout_map(timeout_map)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic pe_pass(input logic stuck);
    logic [15:0] p;
    logic [15:0] r;
    p = stuck ? 16'h0 : op1 * op2;
    r = p + addo;
    return r == expv;
  endfunction

  // behavioural PE: complete drops after start, returns 2 cycles later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      comp <= '1;
      res  <= '0;
      for (int i = 0; i < NP; i++) cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (load_en[i]) res[i] <= pe_pass(mul_stuck[i]);
        if (start[i] && !noack[i]) begin
          comp[i] <= 1'b0;
          cnt[i]  <= 2'd2;
        end else if (cnt[i] != 0 && !hang[i]) begin
          cnt[i] <= cnt[i] - 2'd1;
          if (cnt[i] == 2'd1) comp[i] <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk)
    if (!rst)
      for (int i = 0; i < NP; i++)
        if (start[i]) start_log.push_back(i);

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert ($onehot0(load_en) && $onehot0(start)
              && !(|load_en && |start))
      else begin
        errors++;
        $error("FAIL strobe_excl obs=%b/%b", load_en, start);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic go();
    start_log.delete();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int cyc);
    cyc = 0;
    while (!sweep_done && cyc < lim) begin
      tick();
      cyc++;
    end
    chk("done_seen", {31'd0, sweep_done}, 32'd1);
  endtask

  task automatic wait_start(input int pe);
    k = 0;
    while (!start[pe] && k < 200) begin
      tick();
      k++;
    end
    chk("start_seen", {31'd0, start[pe]}, 32'd1);
  endtask

  initial begin
    #1;
    do_reset();
    chk("rst_busy", {31'd0, sweep_busy}, 32'd0);
    chk("rst_fault", {28'd0, fault_map}, 32'd0);
    chk("rst_op1", {16'd0, op1}, 32'd0);
    chk("rst_load", {28'd0, load_en}, 32'd0);

    // first vector operands and full passing sweep
    go();
    chk("t1_op1", {16'd0, op1}, 32'h0000ACE1);
    chk("t1_op2", {16'd0, op2}, 32'h00009C35);
    chk("t1_add", {16'd0, addo}, 32'h0000531E);
    chk("t1_exp", {16'd0, expv}, 32'h000039B3);
    chk("t1_load", {28'd0, load_en}, 32'h1);
    chk("t1_busy", {31'd0, sweep_busy}, 32'd1);
    n = 0;
    while (!sweep_done && n < 200) begin
      tick();
      n++;
      if (n == 6) begin
        chk("t2_v1_load", {28'd0, load_en}, 32'h1);
        chk("t2_v1_op1", {16'd0, op1}, 32'h000059C3);
      end
      if (n == 12)
        chk("t2_pe1_load", {28'd0, load_en}, 32'h2);
    end
    chk("t2_latency", n, 32'd48);
    chk("t2_fault", {28'd0, fault_map}, 32'd0);
    chk("t2_nstart", start_log.size(), 32'd8);
    for (int i = 0; i < start_log.size() && i < 8; i++)
      chk("t2_order", start_log[i], i / 2);
    tick();
    chk("t2_done_pulse", {31'd0, sweep_done}, 32'd0);
    chk("t2_idle", {31'd0, sweep_busy}, 32'd0);

    // PE 2 multiplier stuck at zero
    do_reset();
    mul_stuck = 4'b0100;
    go();
    wait_done(200, n);
    chk("t3_fault", {28'd0, fault_map}, 32'h4);
    k = 0;
    foreach (start_log[i]) if (start_log[i] == 2) k++;
    chk("t3_pe2_starts", k, 32'd1);
    chk("t3_nstart", start_log.size(), 32'd7);
    mul_stuck = '0;

    // start while array busy is dropped, not queued
    do_reset();
    array_idle = 1'b0;
    sweep_start = 1'b1;
    tick();
    tick();
    chk("t4_busy_a", {31'd0, sweep_busy}, 32'd0);
    chk("t4_load_a", {28'd0, load_en}, 32'd0);
    sweep_start = 1'b0;
    array_idle = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_busy_b", {31'd0, sweep_busy}, 32'd0);

    // abort in WAIT_DONE of PE 1 (PE 0 faulty, PE 1 hangs)
    do_reset();
    mul_stuck = 4'b0001;
    hang = 4'b0010;
    go();
    wait_start(1);
    tick();
    tick();
    tick();
    chk("t5_pre_busy", {31'd0, sweep_busy}, 32'd1);
    sweep_abort = 1'b1;
    tick();
    sweep_abort = 1'b0;
    chk("t5_busy", {31'd0, sweep_busy}, 32'd0);
    chk("t5_strobes", {24'd0, load_en, start}, 32'd0);
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (sweep_done) k++;
      tick();
    end
    chk("t5_no_done", k, 32'd0);
    chk("t5_fault", {28'd0, fault_map}, 32'h1);

    // async reset mid-sweep
    go();
    wait_start(1);
    tick();
    chk("t5_fault_pre", {28'd0, fault_map}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", {31'd0, sweep_busy}, 32'd0);
    chk("t5_rst_fault", {28'd0, fault_map}, 32'd0);
    chk("t5_rst_ops", {op1, expv}, 32'd0);
    chk("t5_rst_strb", {24'd0, load_en, start}, 32'd0);
    mul_stuck = '0;
    hang = '0;
    tick();
    rst = 1'b0;
    tick();

`ifdef STW_TIMEOUT_EN
    // PE 3 never drops complete: watchdog marks it
    do_reset();
    noack = 4'b1000;
    go();
    wait_done(300, n);
    chk("t6_latency", n, 32'd53);
    chk("t6_fault", {28'd0, fault_map}, 32'h8);
    chk("t6_tmap", {28'd0, timeout_map}, 32'h8);
    noack = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
